// File: rtl/mem_responder.sv
// Byte-wide RAM/IO responder: single-port byte RAM, TX console FIFO and sticky halt flag.
// RAM contents are undefined until written.
module mem_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH  = 8,
  parameter int FULL_MARGIN = 2,
  parameter     INIT_FILE   = "test.data"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic        tx_overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] THRESH_C = (PW+1)'(FIFO_DEPTH - FULL_MARGIN);

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [7:0]            fifo [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [PW:0]           count;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  is_io, io_wr, push_req, push, pop;
  logic                  unused_addr;

  // RAM index aliases; only the IO window bits and the index are meaningful.
  assign unused_addr = ^mem_a;

  assign idx      = mem_a[ADDR_WIDTH-1:0];
  assign is_io    = (mem_a[17:16] == 2'b11);
  assign io_wr    = !rst && mem_wr && is_io;
  assign pop      = tx_valid && tx_ready;
  assign push_req = io_wr && (mem_a[15:0] == 16'h0000);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push     = push_req && ((count != DEPTH_C) || pop);

  assign tx_valid       = (count != '0);
  assign tx_data        = tx_valid ? fifo[rd_ptr] : 8'h00;
  assign io_buffer_full = (count >= THRESH_C);

  always_ff @(posedge clk) begin
    if (!rst && mem_wr && !is_io)
      ram[idx] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst)
      mem_din <= 8'h00;
    else if (!mem_wr)
      mem_din <= is_io ? 8'h00 : ram[idx];
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      halt        <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push)
        tx_overflow <= 1'b1;
      if (io_wr && mem_a[15:0] == 16'h0004)
        halt <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver updates a queue/array reference model and
// queues per-cycle expectations; a monitor pops them after each rising edge and compares.
module tb_mem_responder;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic        tx_overflow;

  mem_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .halt(halt), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    bit         din_known;
    bit         valid;
    logic [7:0] data;
    bit         full;
    bit         ovf;
    bit         halt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_q[$];
  logic [7:0] m_ram[int];
  logic [7:0] m_din = 8'h00;
  bit         m_din_known = 1'b0;
  bit         m_halt = 1'b0;
  bit         m_ovf = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge and advance the model across the next rising edge.
  task automatic step(input logic r, input logic [31:0] a, input logic w,
                      input logic [7:0] d, input logic rdy);
    exp_t e;
    bit   pop, acc, io;
    int   idx;
    @(negedge clk);
    rst = r; mem_a = a; mem_wr = w; mem_dout = d; tx_ready = rdy;
    if (r) begin
      m_q.delete();
      m_halt = 0; m_ovf = 0; m_din = 8'h00; m_din_known = 1;
    end else begin
      io  = (a[17:16] == 2'b11);
      idx = int'(a[16:0]);
      pop = (m_q.size() != 0) && rdy;
      acc = 0;
      if (w) begin
        if (io) begin
          if (a[15:0] == 16'h0000) begin
            if (m_q.size() < DEPTH || pop) acc = 1;
            else m_ovf = 1;
          end else if (a[15:0] == 16'h0004) m_halt = 1;
        end else m_ram[idx] = d;
      end else if (io) begin
        m_din = 8'h00; m_din_known = 1;
      end else if (m_ram.exists(idx)) begin
        m_din = m_ram[idx]; m_din_known = 1;
      end else m_din_known = 0;
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(d);
    end
    e.din = m_din; e.din_known = m_din_known;
    e.valid = (m_q.size() != 0);
    e.data  = e.valid ? m_q[0] : 8'h00;
    e.full  = (m_q.size() >= DEPTH - MARGIN);
    e.ovf   = m_ovf;
    e.halt  = m_halt;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.din_known) chk("mem_din", mem_din, e.din);
        chk("tx_valid", {7'b0, tx_valid}, {7'b0, e.valid});
        chk("tx_data", tx_data, e.data);
        chk("io_buffer_full", {7'b0, io_buffer_full}, {7'b0, e.full});
        chk("tx_overflow", {7'b0, tx_overflow}, {7'b0, e.ovf});
        chk("halt", {7'b0, halt}, {7'b0, e.halt});
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : driver
    logic [31:0] a;
    int          sel;
    rst = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0; tx_ready = 1'b0;
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    // RAM write/read, then a write cycle must hold mem_din
    step(0, 32'h10, 1, 8'hA5, 0);
    step(0, 32'h10, 0, 8'h00, 0);
    step(0, 32'h44, 1, 8'h11, 0);
    step(0, 32'h44, 0, 8'h00, 0);
    // Back-to-back reads of an instruction word
    step(0, 32'h100, 1, 8'h13, 0);
    step(0, 32'h101, 1, 8'h05, 0);
    step(0, 32'h102, 1, 8'h00, 0);
    step(0, 32'h103, 1, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 32'h100 + i, 0, 8'h00, 0);
    // Fill FIFO, overflow, then full push with simultaneous pop
    for (int i = 0; i < DEPTH; i++) step(0, 32'h30000, 1, 8'h41 + 8'(i), 0);
    step(0, 32'h30000, 1, 8'h5A, 0);
    step(0, 32'h30000, 1, 8'h5B, 1);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 32'h30008, 0, 8'h00, 1);
    // IO read and RAM aliasing
    step(0, 32'h30000, 0, 8'h00, 0);
    step(0, 32'h20, 1, 8'h77, 0);
    step(0, 32'h20020, 0, 8'h00, 0);
    // Halt, then reset with a suppressed RAM write
    step(0, 32'h30000, 1, 8'h99, 0);
    step(0, 32'h30004, 1, 8'h01, 0);
    step(0, 32'h40, 0, 8'h00, 0);
    step(0, 32'h20, 1, 8'h33, 0);
    step(1, 32'h20, 1, 8'hEE, 0);
    step(0, 32'h20, 0, 8'h00, 0);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 55) begin
        a = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 2)) << 16) | 32'($urandom_range(0, 63));
      end else if (sel < 90) a = 32'h30000;
      else if (sel < 93) a = 32'h30004;
      else a = 32'h30000 | (32'($urandom_range(2, 255)) << 2);
      step(($urandom_range(0, 199) == 0), a, 1'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0));
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
